// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator: K-1 line buffers feed a KxK shift array,
// and each complete neighbourhood is presented as one flat bus for the MAC stage.
module conv_window_gen #(
    parameter int DATA_SIZE = 16,
    parameter int IMG_W     = 32,
    parameter int IMG_H     = 32,
    parameter int K         = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din_valid,
    input  logic [DATA_SIZE-1:0]        din,
    output logic [DATA_SIZE*K*K-1:0]    window,
    output logic                        window_valid,
    output logic [7:0]                  out_row,
    output logic [7:0]                  out_col,
    output logic                        frame_done
);

    localparam int KK = K * K;
    localparam int WW = DATA_SIZE * KK;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] COL_LAST  = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_LAST  = 8'(IMG_H - 1);
    localparam logic [7:0] ROW_PRIME = 8'(K - 2);
    localparam logic [7:0] EDGE      = 8'(K - 1);

    typedef enum logic {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             col_cnt_q, col_cnt_d;
    logic [7:0]             row_cnt_q, row_cnt_d;
    logic [DATA_SIZE-1:0]   win_q [K][K];
    logic [DATA_SIZE-1:0]   win_d [K][K];
    logic [WW-1:0]          window_q, window_d;
    logic                   window_valid_q, window_valid_d;
    logic [7:0]             out_row_q, out_row_d;
    logic [7:0]             out_col_q, out_col_d;
    logic                   frame_done_q, frame_done_d;

    // Line buffer j holds row (current-1-j); index 0 is the newest row.
    logic [DATA_SIZE-1:0]   lb_mem [K-1][IMG_W];
    logic [DATA_SIZE-1:0]   lb_rd_s [K-1];
    logic [DATA_SIZE-1:0]   col_s [K];
    logic [AW-1:0]          addr_s;
    logic                   last_col_s;
    logic                   last_pix_s;
    logic                   emit_s;

    assign addr_s     = col_cnt_q[AW-1:0];
    assign last_col_s = (col_cnt_q == COL_LAST);
    assign last_pix_s = last_col_s && (row_cnt_q == ROW_LAST);
    assign emit_s     = din_valid && (state_q == STREAM) && (col_cnt_q >= EDGE);

    // Line-buffer read taps and the incoming column, oldest row on top.
    always_comb begin
        for (int j = 0; j < K - 1; j++) begin
            lb_rd_s[j] = lb_mem[j][addr_s];
        end
        for (int r = 0; r < K - 1; r++) begin
            col_s[r] = lb_rd_s[K-2-r];
        end
        col_s[K-1] = din;
    end

    // Delay-line write: each buffer passes its old column entry one buffer further.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb_mem[0][addr_s] <= din;
            for (int j = 1; j < K - 1; j++) begin
                lb_mem[j][addr_s] <= lb_rd_s[j-1];
            end
        end
    end

    // Next-state: counters, FSM, window shift and output capture.
    always_comb begin
        state_d        = state_q;
        col_cnt_d      = col_cnt_q;
        row_cnt_d      = row_cnt_q;
        win_d          = win_q;
        window_d       = window_q;
        window_valid_d = 1'b0;
        out_row_d      = out_row_q;
        out_col_d      = out_col_q;
        frame_done_d   = 1'b0;

        if (din_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][K-1] = col_s[r];
            end
            if (last_col_s) begin
                col_cnt_d = 8'd0;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d = 8'd0;
                end else begin
                    row_cnt_d = row_cnt_q + 8'd1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 8'd1;
            end
        end else begin
            col_cnt_d = col_cnt_q;
        end

        case (state_q)
            FILL: begin
                if (din_valid && last_col_s && (row_cnt_q == ROW_PRIME)) begin
                    state_d = STREAM;
                end else begin
                    state_d = FILL;
                end
            end
            STREAM: begin
                if (din_valid && last_pix_s) begin
                    state_d = FILL;
                end else begin
                    state_d = STREAM;
                end
            end
            default: state_d = FILL;
        endcase

        // Top-left element lands in the MSBs, bottom-right in the LSBs.
        if (emit_s) begin
            window_valid_d = 1'b1;
            frame_done_d   = last_pix_s;
            out_row_d      = row_cnt_q - EDGE;
            out_col_d      = col_cnt_q - EDGE;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    window_d[DATA_SIZE*(KK-(r*K+c))-1 -: DATA_SIZE] = win_d[r][c];
                end
            end
        end else begin
            window_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FILL;
            col_cnt_q      <= 8'd0;
            row_cnt_q      <= 8'd0;
            window_q       <= '0;
            window_valid_q <= 1'b0;
            out_row_q      <= 8'd0;
            out_col_q      <= 8'd0;
            frame_done_q   <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            state_q        <= state_d;
            col_cnt_q      <= col_cnt_d;
            row_cnt_q      <= row_cnt_d;
            window_q       <= window_d;
            window_valid_q <= window_valid_d;
            out_row_q      <= out_row_d;
            out_col_q      <= out_col_d;
            frame_done_q   <= frame_done_d;
            win_q          <= win_d;
        end
    end

    assign window       = window_q;
    assign window_valid = window_valid_q;
    assign out_row      = out_row_q;
    assign out_col      = out_col_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x6 image with K=5; expected windows
// are rebuilt from the pixel formula p = base + 8*r + c.
module tb_conv_window_gen;

    localparam int DS = 16;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int KS = 5;
    localparam int WB = DS * KS * KS;

    logic           clk = 1'b0;
    logic           rst;
    logic           din_valid;
    logic [DS-1:0]  din;
    logic [WB-1:0]  window;
    logic           window_valid;
    logic [7:0]     out_row;
    logic [7:0]     out_col;
    logic           frame_done;

    int             errors = 0;
    int             checks = 0;
    int             br = 0;
    int             bc = 0;
    int             wins = 0;
    logic [WB-1:0]  last_win = '0;

    conv_window_gen #(
        .DATA_SIZE(DS), .IMG_W(W), .IMG_H(H), .K(KS)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .window(window), .window_valid(window_valid),
        .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [WB-1:0] exp_win(input int base, input int orow, input int ocol);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < KS * KS; i++) begin
            w[DS*(KS*KS-i)-1 -: DS] = 16'(base + W * (orow + i / KS) + ocol + i % KS);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns after the rising edge.
    task automatic step(input int base, input bit v);
        logic [WB-1:0] ew;
        bit            emit;
        @(negedge clk);
        din_valid = v;
        din       = v ? 16'(base + W * br + bc) : 16'hdead;
        @(posedge clk);
        #1;
        emit = v && (br >= KS - 1) && (bc >= KS - 1);
        if (emit) begin
            ew = exp_win(base, br - (KS - 1), bc - (KS - 1));
            chk("valid", WB'(window_valid), WB'(1'b1));
            chk("out_row", WB'(out_row), WB'(br - (KS - 1)));
            chk("out_col", WB'(out_col), WB'(bc - (KS - 1)));
            chk("window", window, ew);
            chk("frame_done", WB'(frame_done), WB'((br == H - 1) && (bc == W - 1)));
            last_win = ew;
            wins++;
        end else begin
            chk("no_valid", WB'(window_valid), WB'(1'b0));
            chk("no_done", WB'(frame_done), WB'(1'b0));
            chk("hold_window", window, last_win);
        end
        if (v) begin
            if (bc == W - 1) begin
                bc = 0;
                br = (br == H - 1) ? 0 : br + 1;
            end else begin
                bc++;
            end
        end
    endtask

    task automatic send_frame(input int base, input bit bubbles);
        logic [15:0] pat;
        int          n;
        int          k;
        bit          v;
        pat = 16'b1001_1011_0010_1101;
        n = 0;
        k = 0;
        while (n < W * H) begin
            v = bubbles ? pat[k % 16] : 1'b1;
            step(base, v);
            if (v) n++;
            k++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_window", window, '0);
        chk("rst_valid", WB'(window_valid), WB'(1'b0));
        chk("rst_row", WB'(out_row), WB'(0));
        chk("rst_col", WB'(out_col), WB'(0));
        chk("rst_done", WB'(frame_done), WB'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // Continuous frame.
        wins = 0;
        send_frame(0, 1'b0);
        chk("count_cont", WB'(wins), WB'(8));

        // Same image with input bubbles.
        wins = 0;
        send_frame(0, 1'b1);
        chk("count_bubble", WB'(wins), WB'(8));

        // Back-to-back frames, no idle cycle between them.
        wins = 0;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        chk("count_b2b", WB'(wins), WB'(16));

        // Partial frame, then asynchronous reset mid-cycle.
        for (int i = 0; i < 30; i++) step(200, 1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_window", window, '0);
        chk("mid_rst_valid", WB'(window_valid), WB'(1'b0));
        chk("mid_rst_row", WB'(out_row), WB'(0));
        chk("mid_rst_col", WB'(out_col), WB'(0));
        chk("mid_rst_done", WB'(frame_done), WB'(1'b0));
        br = 0;
        bc = 0;
        last_win = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        wins = 0;
        send_frame(0, 1'b0);
        chk("count_after_rst", WB'(wins), WB'(8));

        @(negedge clk);
        din_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
